// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant: round-robin (FIXED_PRI = 0) or port 0 always first (FIXED_PRI = 1).
// lastGrant only moves when the grant is actually taken (hs).
module dmem_rr_arb
    import dmem_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req0_valid,
    input  logic     req1_valid,
    input  logic     hs,
    output logic     gnt_valid,
    output port_id_t gnt_id
);

    port_id_t last_grant_q;
    port_id_t last_grant_d;

    // Grant selection and lastGrant update on handshake
    always_comb begin
        gnt_valid    = req0_valid | req1_valid;
        gnt_id       = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRI != 0) begin
                gnt_id = 1'b0;
            end else begin
                gnt_id = ~last_grant_q;
            end
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
        last_grant_d = hs ? gnt_id : last_grant_q;
    end

    // lastGrant resets to 1 so port 0 wins the first contested cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-ported data memory between the CPU MEM stage
// (port 0) and the debug/DMA loader (port 1). One transaction in flight.
// Optional macro DMEM_ARB_BOUNDS_CHECK_EN: out-of-range addresses skip the
// memory and respond with rdata 0 plus an rsp*Err pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate, grant ready to one port, latch request on handshake
// ACCESS  | drive memory for one cycle from the latched request
// RESPOND | pulse rspValid to the owning port with read data / store ack
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0Valid,
    output logic              req0Ready,
    input  logic              req0Write,
    input  logic [ADDR_W-1:0] req0Addr,
    input  logic [DATA_W-1:0] req0Wdata,
    input  logic              req1Valid,
    output logic              req1Ready,
    input  logic              req1Write,
    input  logic [ADDR_W-1:0] req1Addr,
    input  logic [DATA_W-1:0] req1Wdata,
    output logic              rsp0Valid,
    output logic [DATA_W-1:0] rsp0Rdata,
    output logic              rsp1Valid,
    output logic [DATA_W-1:0] rsp1Rdata,
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    output logic              rsp0Err,
    output logic              rsp1Err,
`endif
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    port_id_t          owner_q, owner_d;

    logic              gnt_valid;
    port_id_t          gnt_id;
    logic              hs;
    logic              addr_err;
    logic              mem_go;
    logic              rsp_go;
    logic [DATA_W-1:0] rsp_data;

    assign hs = (state_q == IDLE) && gnt_valid;

    dmem_rr_arb #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0Valid),
        .req1_valid (req1Valid),
        .hs         (hs),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    assign addr_err = (addr_q >= ADDR_W'(DEPTH));
`else
    // Without the range check DEPTH has no effect on the datapath.
    logic depth_unused;
    assign depth_unused = (DEPTH > 0);
    assign addr_err     = 1'b0;
`endif

    // Next-state logic and request capture on handshake
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = ACCESS;
                    owner_d = gnt_id;
                    if (gnt_id == 1'b1) begin
                        we_d    = req1Write;
                        addr_d  = req1Addr;
                        wdata_d = req1Wdata;
                    end else begin
                        we_d    = req0Write;
                        addr_d  = req0Addr;
                        wdata_d = req0Wdata;
                    end
                end
            end
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake, memory strobes and response outputs, all zero outside their state
    always_comb begin
        req0Ready = hs && (gnt_id == 1'b0);
        req1Ready = hs && (gnt_id == 1'b1);

        mem_go   = (state_q == ACCESS) && !addr_err;
        memEn    = mem_go;
        memWe    = mem_go && we_q;
        memAddr  = mem_go ? addr_q  : '0;
        memWdata = mem_go ? wdata_q : '0;

        rsp_go    = (state_q == RESPOND);
        rsp_data  = (we_q || addr_err) ? '0 : memRdata;
        rsp0Valid = rsp_go && (owner_q == 1'b0);
        rsp1Valid = rsp_go && (owner_q == 1'b1);
        rsp0Rdata = rsp0Valid ? rsp_data : '0;
        rsp1Rdata = rsp1Valid ? rsp_data : '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        rsp0Err   = rsp0Valid && addr_err;
        rsp1Err   = rsp1Valid && addr_err;
`endif
    end

    // State and latched request registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between two requesters: port 0 is the CPU MEM stage, port 1 is the debug/DMA loader.
- Each port uses a valid/ready request handshake and gets a one-cycle response pulse.
- The arbiter registers each accepted request, drives the memory for exactly one cycle, then returns read data or a write acknowledgement.
- It sits between the pipeline's MEM stage and the data memory, replacing the direct address/write-enable wiring.

Parameters:
- ADDR_W, 32, byte address width of requests and memory address.
- DATA_W, 32, data word width.
- DEPTH, 256, number of addressable memory locations (used by the optional bounds check).
- FIXED_PRI, 0, arbitration mode: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0Valid / req1Valid  in  1  request present on port 0 / port 1.
- req0Ready / req1Ready  out  1  request accepted this cycle.
- req0Write / req1Write  in  1  1 = store, 0 = load.
- req0Addr / req1Addr  in  ADDR_W  request address.
- req0Wdata / req1Wdata  in  DATA_W  store data.
- rsp0Valid / rsp1Valid  out  1  one-cycle response pulse.
- rsp0Rdata / rsp1Rdata  out  DATA_W  load data; 0 for store acknowledgements.
- memEn  out  1  memory access strobe.
- memWe  out  1  memory write enable, qualified by memEn.
- memAddr  out  ADDR_W  memory address.
- memWdata  out  DATA_W  memory write data.
- memRdata  in  DATA_W  memory read data, valid in the cycle after memEn.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE, lastGrant = 1 (so port 0 wins first). All outputs are 0: ready, rspValid, rspRdata and all mem* outputs.
- State machine: IDLE -> ACCESS -> RESPOND -> IDLE, with one transaction in flight at a time.
- IDLE:
  - Grant is computed combinationally from the valid inputs.
  - Only the granted port sees ready = 1; ready is 0 in every other state.
  - On valid && ready, latch write/addr/wdata and the granted port id, then go to ACCESS.
  - With no valid input, stay in IDLE.
- Arbitration:
  - When only one port is valid, that port wins.
  - When both are valid and FIXED_PRI = 0, the port not equal to lastGrant wins.
  - When both are valid and FIXED_PRI = 1, port 0 wins.
  - lastGrant updates only on a handshake.
- ACCESS:
  - memEn = 1 for exactly this cycle.
  - memWe = the latched write bit; memAddr and memWdata are the latched values.
  - Next state is RESPOND.
- RESPOND:
  - The owning port's rspValid = 1 for exactly one cycle.
  - rspRdata = memRdata for a load, 0 for a store.
  - The other port's rspValid stays 0. Next state is IDLE.
- Latency and throughput: the response arrives 2 cycles after the handshake; the maximum rate is one transaction per 3 cycles.
- No response backpressure: requesters must accept the rspValid pulse.
- Request inputs are ignored outside the handshake cycle; changes during ACCESS/RESPOND have no effect.
- Outside ACCESS, mem* outputs hold 0, so there are no spurious writes.
- Reset mid-operation: the in-flight transaction is dropped and no response is issued. If reset occurs during ACCESS, memEn deasserts immediately (asynchronous).
- Addresses pass through unmodified; DEPTH is used only by the optional bounds check.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A latched address >= DEPTH suppresses memEn in ACCESS; the memory is not touched.
  - RESPOND still pulses rspValid with rspRdata = 0.
  - Extra outputs rsp0Err / rsp1Err pulse alongside rspValid for these requests; both reset to 0.
- Undefined:
  - No range check; every accepted request reaches the memory.
  - The rsp*Err ports do not exist.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, ACCESS, RESPOND);
  - the port-id typedef (1 bit);
  - ADDR_W, DATA_W and DEPTH defaults.
- One natural sub-module, dmem_rr_arb: a 2-way round-robin/fixed-priority grant with a lastGrant register updated on handshake.
- Everything else stays in dmem_arbiter.

Test Plan:
- After reset, port 0 loads addr 3 with mem[3] = 0x30000033:
  - memEn = 1, memWe = 0, memAddr = 3 one cycle after the handshake;
  - rsp0Valid = 1 with rsp0Rdata = 0x30000033 two cycles after the handshake;
  - rsp1Valid stays 0.
- Port 1 stores 0xDEADBEEF to addr 5, then loads addr 5:
  - memWe = 1 for exactly one cycle, and rsp1Rdata = 0 for the store ack;
  - the following load returns 0xDEADBEEF.
- Both ports hold valid continuously, FIXED_PRI = 0: grants alternate 0,1,0,1 and each response goes only to its requester. With FIXED_PRI = 1, port 0 is granted every time.
- Port 0 issues a request while a port 1 transaction is in ACCESS: req0Ready stays 0 until IDLE, then port 0 is accepted. Changing req0Addr before acceptance has no effect on the in-flight access.
- Assert rst_n = 0 during ACCESS: memEn drops to 0 immediately and no rspValid follows. After release, a new request completes normally.
- With DMEM_ARB_BOUNDS_CHECK_EN, a load from addr 300 (DEPTH 256): memEn is never asserted, and rsp0Valid = 1 with rsp0Err = 1 and rsp0Rdata = 0.
